sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Arbitrates and sequences the single external asynchronous SRAM between two requesters: the bootstrap loader, which writes 16-bit words copied from SPI flash, and the microprocessor, which reads and writes.
- Latches one request at a time, drives the SRAM control strobes with a programmable access window, and returns an ack (plus read data for micro reads).
- Sits between the bootstrap/micro cores and the SRAM pins.

Parameters:
- ADDR_W, 22, SRAM word-address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 7, cycles the strobe (we/oe) stays asserted; legal range 1..15.

Ports:
- master_clk_i  in  1  system clock; all logic on rising edge.
- master_rst_i  in  1  asynchronous, active-high reset.
- boot_active_i  in  1  bootstrap in progress; gives bootstrap priority.
- boot_req_i  in  1  bootstrap write request (level).
- boot_addr_i  in  ADDR_W  bootstrap write address.
- boot_wdata_i  in  DATA_W  bootstrap write data.
- boot_ack_o  out  1  one-cycle pulse when the bootstrap write completes.
- micro_req_i  in  1  micro request (level).
- micro_we_i  in  1  1 = write, 0 = read.
- micro_be_i  in  2  byte enables {ub,lb}, active-high.
- micro_addr_i  in  ADDR_W  micro address.
- micro_wdata_i  in  DATA_W  micro write data.
- micro_rdata_o  out  DATA_W  micro read data; valid with micro_ack_o and held until the next micro read.
- micro_ack_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.
- grant_o  out  1  owner of the current or last transfer: 0 = boot, 1 = micro.
- sram_address_o  out  ADDR_W  SRAM address.
- sram_datain_o  out  DATA_W  write data to SRAM.
- sram_dataout_i  in  DATA_W  read data from SRAM.
- sram_dq_oe_o  out  1  data-pad output enable; 1 during write transfers.
- sram_cs_o, sram_we_o, sram_oe_o, sram_adv_o  out  1 each  active-low strobes.
- sram_lb_ub_o  out  2  active-low byte lanes {ub,lb}.

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - FSM returns to IDLE.
  - sram_cs_o, sram_we_o, sram_oe_o and sram_adv_o = 1; sram_lb_ub_o = 2'b11.
  - Address, data, micro_rdata_o, acks, busy_o, grant_o and sram_dq_oe_o = 0.
  - An interrupted transfer is lost; no ack is issued for it.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Requests are sampled here only.
  - If boot_active_i = 1, boot_req_i wins; otherwise micro_req_i wins.
  - A simultaneous request from the loser is left pending and is served after the current transfer, as long as it is still asserted in IDLE.
  - On a grant, latch the address, write data, byte enables, direction and grant_o, then go to SETUP.
  - Bootstrap transfers are always full-word writes (lb_ub = 00).
- SETUP (1 cycle):
  - Drive address, sram_cs_o = 0 and sram_adv_o = 0.
  - sram_lb_ub_o = inverted enables.
  - For writes, drive sram_datain_o and sram_dq_oe_o = 1.
- STROBE (WAIT_CYCLES cycles, 4-bit down-counter):
  - Writes: sram_we_o = 0. Reads: sram_oe_o = 0.
  - sram_adv_o returns to 1.
  - For reads, sram_dataout_i is captured into micro_rdata_o on the last STROBE cycle.
- HOLD (1 cycle):
  - we/oe return to 1; cs, address and data are held.
  - The matching ack pulses this cycle.
  - Next cycle: IDLE, cs = 1, dq_oe = 0.
- Latency: a request sampled in IDLE at cycle N produces its ack at cycle N + WAIT_CYCLES + 2. Back-to-back throughput is one transfer per WAIT_CYCLES + 3 cycles.
- Requests are not re-checked after the grant. Deasserting a request or changing its inputs mid-transfer has no effect; the transfer completes with the latched values.
- A requester must drop req the cycle after its ack, otherwise it is re-served. Each ack equals exactly one transfer.
- micro_be_i = 00 on a micro request: the transfer runs with both lanes disabled, no data changes, and ack is still given.

Decomposition:
- Shared package holds the FSM state encoding (IDLE/SETUP/STROBE/HOLD), the GRANT_BOOT/GRANT_MICRO constants and the strobe idle levels.
- Natural sub-module: sram_timing_fsm (SETUP/STROBE/HOLD sequencer with its wait counter); the top keeps the arbitration and request latching.

Test Plan:
- Reset then boot write (boot_active_i = 1, addr 0x00010, data 0xBEEF, WAIT_CYCLES = 7):
  - we low for exactly 7 cycles, lb_ub = 00.
  - boot_ack_o at request cycle + 9, address bus = 0x00010.
- Micro read (boot_active_i = 0, addr 0x3FFFFF, sram_dataout_i = 0x1234):
  - oe low for 7 cycles, dq_oe = 0.
  - micro_rdata_o = 0x1234 with micro_ack_o.
- Simultaneous requests:
  - With boot_active_i = 1, boot is served first and micro is served after, with acks 10 cycles apart.
  - With boot_active_i = 0 the order reverses.
- Micro byte write, be = 2'b10, data 0xAB00: sram_lb_ub_o = 2'b01 during SETUP..HOLD.
- Reset asserted in the 3rd STROBE cycle:
  - All strobes go to 1 immediately and no ack is issued.
  - After release, a new request completes normally.
- micro_req_i dropped in SETUP: the transfer still completes and exactly one micro_ack_o is issued.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: transfer FSM states, grant
// owner codes and the idle levels of the active-low SRAM strobes.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } xfer_state_e;

  localparam logic GRANT_BOOT  = 1'b0;
  localparam logic GRANT_MICRO = 1'b1;

  localparam logic       STROBE_OFF = 1'b1;
  localparam logic [1:0] LANES_OFF  = 2'b11;
  localparam logic [1:0] BE_FULL    = 2'b11;

  // Byte-lane pins are active-low and only driven while a transfer owns the bus.
  function automatic logic [1:0] lane_strobes(input logic active, input logic [1:0] be);
    return active ? ~be : LANES_OFF;
  endfunction

endpackage

// File: rtl/sram_timing_fsm.sv
// SETUP -> STROBE -> HOLD sequencer for one SRAM access; the strobe window
// length comes from WAIT_CYCLES (1..15) via a 4-bit down-counter.
module sram_timing_fsm
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 7
) (
  input  logic        master_clk_i,
  input  logic        master_rst_i,
  input  logic        start,
  output xfer_state_e state,
  output logic        last_strobe
);

  xfer_state_e state_nxt;
  logic [3:0]  wait_cnt;

  assign last_strobe = (state == ST_STROBE) && (wait_cnt == 4'd1);

  always_ff @(posedge master_clk_i or posedge master_rst_i) begin
    if (master_rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      // Loaded in SETUP so the first STROBE cycle already sees the full count.
      if (state == ST_SETUP)
        wait_cnt <= 4'(WAIT_CYCLES);
      else if (state == ST_STROBE)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: if (last_strobe) state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the external async SRAM: bootstrap loader writes
// and micro reads/writes, one latched request at a time.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 7
) (
  input  logic              master_clk_i,
  input  logic              master_rst_i,
  input  logic              boot_active_i,
  input  logic              boot_req_i,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic [DATA_W-1:0] boot_wdata_i,
  output logic              boot_ack_o,
  input  logic              micro_req_i,
  input  logic              micro_we_i,
  input  logic [1:0]        micro_be_i,
  input  logic [ADDR_W-1:0] micro_addr_i,
  input  logic [DATA_W-1:0] micro_wdata_i,
  output logic [DATA_W-1:0] micro_rdata_o,
  output logic              micro_ack_o,
  output logic              busy_o,
  output logic              grant_o,
  output logic [ADDR_W-1:0] sram_address_o,
  output logic [DATA_W-1:0] sram_datain_o,
  input  logic [DATA_W-1:0] sram_dataout_i,
  output logic              sram_dq_oe_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic              sram_oe_o,
  output logic              sram_adv_o,
  output logic [1:0]        sram_lb_ub_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic              we;
  } req_t;

  xfer_state_e state;
  logic        last_strobe;
  logic        start;
  logic        pick_micro;
  logic        in_xfer;
  logic        grant_q;
  req_t        cur;
  req_t        boot_req;
  req_t        micro_req;

  sram_timing_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) u_timing (
    .master_clk_i (master_clk_i),
    .master_rst_i (master_rst_i),
    .start        (start),
    .state        (state),
    .last_strobe  (last_strobe)
  );

  // Boot only loses to micro when the loader is not in progress.
  assign pick_micro = micro_req_i && !(boot_active_i && boot_req_i);
  assign start      = (state == ST_IDLE) && (boot_req_i || micro_req_i);

  assign boot_req  = '{addr: boot_addr_i, wdata: boot_wdata_i, be: BE_FULL, we: 1'b1};
  assign micro_req = '{addr: micro_addr_i, wdata: micro_wdata_i, be: micro_be_i, we: micro_we_i};

  always_ff @(posedge master_clk_i or posedge master_rst_i) begin
    if (master_rst_i) begin
      cur           <= '0;
      grant_q       <= GRANT_BOOT;
      micro_rdata_o <= '0;
    end else begin
      if (start) begin
        cur     <= pick_micro ? micro_req : boot_req;
        grant_q <= pick_micro ? GRANT_MICRO : GRANT_BOOT;
      end
      if (last_strobe && !cur.we)
        micro_rdata_o <= sram_dataout_i;
    end
  end

  // Pins decode straight from registered state, so async reset idles them at once.
  assign in_xfer        = (state != ST_IDLE);
  assign busy_o         = in_xfer;
  assign grant_o        = grant_q;
  assign sram_address_o = cur.addr;
  assign sram_datain_o  = cur.wdata;
  assign sram_dq_oe_o   = in_xfer && cur.we;
  assign sram_cs_o      = in_xfer ? 1'b0 : STROBE_OFF;
  assign sram_adv_o     = (state == ST_SETUP) ? 1'b0 : STROBE_OFF;
  assign sram_we_o      = (state == ST_STROBE && cur.we)  ? 1'b0 : STROBE_OFF;
  assign sram_oe_o      = (state == ST_STROBE && !cur.we) ? 1'b0 : STROBE_OFF;
  assign sram_lb_ub_o   = lane_strobes(in_xfer, cur.be);

  assign boot_ack_o  = (state == ST_HOLD) && (grant_q == GRANT_BOOT);
  assign micro_ack_o = (state == ST_HOLD) && (grant_q == GRANT_MICRO);

endmodule
